// File: rtl/rep_sub_pkg.sv
// Shared types for the repeated-subtraction divider.
// Holds the FSM state encoding and the default operand width.
package rep_sub_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/sub_twos_comp.sv
// Combinational two's-complement subtract stage: a + ~b + 1.
// The carry-out doubles as the a >= b compare for the divider.
module sub_twos_comp #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             no_borrow
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
   end

   assign diff      = sum[WIDTH-1:0];
   assign no_borrow = sum[WIDTH];

endmodule

// File: rtl/rep_sub_divider.sv
// Sequential unsigned divider by repeated subtraction with a
// start/done handshake; latency is quotient + 2 cycles.
module rep_sub_divider
   import rep_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] divisor_q, divisor_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] diff;
   logic             no_borrow;

   sub_twos_comp #(
      .WIDTH(WIDTH)
   ) u_sub (
      .a        (remainder_q),
      .b        (divisor_q),
      .diff     (diff),
      .no_borrow(no_borrow)
   );

   always_comb begin
      state_d     = state_q;
      divisor_d   = divisor_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               divisor_d   = divisor;
               remainder_d = dividend;
               quotient_d  = '0;
               dbz_d       = 1'b0;
               if (divisor == '0) begin
                  state_d    = DONE;
                  dbz_d      = 1'b1;
                  quotient_d = '1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            // carry-out is the only magnitude compare
            if (no_borrow) begin
               remainder_d = diff;
               quotient_d  = quotient_q + {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         divisor_q   <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         divisor_q   <= divisor_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_rep_sub_divider.sv
// Scoreboard bench for rep_sub_divider: a driver pushes expected
// results from plain arithmetic, a negedge monitor pops on done.
module tb_rep_sub_divider;

   localparam int W = 4;
   localparam int BUDGET = (1 << W) + 8;

   typedef struct {
      int q;
      int r;
      int dbz;
      int lat;
      int busy;
      int sc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int   cyc = 0;
   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   busy_cnt = 0;
   exp_t sb[$];
   exp_t last_e;
   exp_t mon_e;

   rep_sub_divider #(
      .WIDTH(W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                    nm, act, exp, cyc);
   endtask

   // Monitor: count busy cycles, compare results whenever done rises.
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_cnt = 0;
      end else begin
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               chk("spurious_done", 1, 0);
            end else begin
               mon_e = sb.pop_front();
               chk("quotient", int'(quotient), mon_e.q);
               chk("remainder", int'(remainder), mon_e.r);
               chk("div_by_zero", int'(div_by_zero), mon_e.dbz);
               chk("done_latency", cyc - mon_e.sc, mon_e.lat);
               chk("busy_cycles", busy_cnt, mon_e.busy);
            end
            busy_cnt = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int a, input int b);
      exp_t e;
      step();
      start    = 1'b1;
      dividend = W'(a);
      divisor  = W'(b);
      e.sc     = cyc;
      if (b == 0) begin
         e.q    = (1 << W) - 1;
         e.r    = a;
         e.dbz  = 1;
         e.lat  = 1;
         e.busy = 0;
      end else begin
         e.q    = a / b;
         e.r    = a % b;
         e.dbz  = 0;
         e.lat  = a / b + 2;
         e.busy = a / b + 1;
      end
      sb.push_back(e);
      last_e = e;
   endtask

   task automatic wait_done(input bit noise);
      int n;
      n = 0;
      forever begin
         step();
         if (done === 1'b1) begin
            start = 1'b0;
            return;
         end
         start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         if (start) begin
            dividend = W'($urandom_range(0, (1 << W) - 1));
            divisor  = W'($urandom_range(0, (1 << W) - 1));
         end
         n++;
         if (n > BUDGET) begin
            chk("done_timeout", 0, 1);
            start = 1'b0;
            return;
         end
      end
   endtask

   task automatic run(input int a, input int b, input bit noise);
      issue(a, b);
      wait_done(noise);
   endtask

   task automatic check_hold(input int n);
      start = 1'b0;
      repeat (n) step();
      chk("hold_quotient", int'(quotient), last_e.q);
      chk("hold_remainder", int'(remainder), last_e.r);
      chk("hold_dbz", int'(div_by_zero), last_e.dbz);
   endtask

   task automatic check_zero(input string nm);
      chk({nm, "_busy"}, int'(busy), 0);
      chk({nm, "_done"}, int'(done), 0);
      chk({nm, "_quotient"}, int'(quotient), 0);
      chk({nm, "_remainder"}, int'(remainder), 0);
      chk({nm, "_dbz"}, int'(div_by_zero), 0);
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) step();
      check_zero("reset");
      rst_n = 1'b1;

      run(13, 4, 1'b0);
      check_hold(3);
      run(15, 1, 1'b0);
      run(3, 7, 1'b0);
      run(0, 5, 1'b0);
      run(9, 0, 1'b0);
      check_hold(2);

      // request during RUN must be dropped
      issue(12, 5);
      step();
      start = 1'b0;
      step();
      start    = 1'b1;
      dividend = W'(1);
      divisor  = W'(1);
      wait_done(1'b0);

      // reset in the middle of a long division
      issue(15, 1);
      repeat (6) begin
         step();
         start = 1'b0;
      end
      chk("busy_before_reset", int'(busy), 1);
      rst_n = 1'b0;
      sb.delete();
      step();
      check_zero("midrun_reset");
      rst_n = 1'b1;
      run(6, 3, 1'b0);

      for (int i = 0; i < 40; i++) begin
         int a;
         int b;
         a = $urandom_range(0, (1 << W) - 1);
         b = ($urandom_range(0, 5) == 0) ? 0 :
             $urandom_range(1, (1 << W) - 1);
         run(a, b, 1'b1);
         if ($urandom_range(0, 3) == 0) check_hold($urandom_range(1, 3));
      end

      start = 1'b0;
      repeat (3) step();
      chk("scoreboard_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
